// File: rtl/r_cpu_ctrl.sv
// r_cpu_ctrl: multi-cycle fetch/decode/execute/writeback sequencer for the
// R-type CPU datapath. Strobes are decoded combinationally from the current
// state so that an asynchronous reset clears them in the same cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped at an instruction boundary, waiting for run
// IF    | fetch; waits for mem_ready, then loads IR and advances PC
// ID    | decode opcode/func into the held ALU controls
// EX    | drive ALU controls, pulse flag-capture enables
// WB    | hold ALU controls, write rd, retire the instruction
// HALT  | halt opcode or illegal instruction; only rst leaves
module r_cpu_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  output logic             PC_Write,
  output logic             IR_Write,
  output logic             Write_Reg,
  output logic [2:0]       ALU_OP,
  output logic             rs_shamt,
  output logic             Set_ZF,
  output logic             Set_OF,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state_r, state_nxt;

  logic [2:0]       alu_op_r;
  logic             shamt_r, zf_r, of_r;
  logic             illegal_r;
  logic [CNT_W-1:0] inst_cnt_r;

  logic       dec_valid;
  logic [2:0] dec_op;
  logic       dec_shamt, dec_zf, dec_of;
  logic       halt_op, bad_inst;

  // Function-field decode table; dec_valid flags a supported func code.
  always_comb begin
    dec_valid = 1'b1;
    dec_op    = 3'b000;
    dec_shamt = 1'b0;
    dec_zf    = 1'b1;
    dec_of    = 1'b0;
    case (func)
      6'b100000: begin dec_op = 3'b100; dec_of = 1'b1; end
      6'b100010: begin dec_op = 3'b101; dec_of = 1'b1; end
      6'b100100: dec_op = 3'b000;
      6'b100101: dec_op = 3'b001;
      6'b100110: dec_op = 3'b010;
      6'b100111: dec_op = 3'b011;
      6'b101011: dec_op = 3'b110;
      6'b000100: dec_op = 3'b111;
      6'b000000: begin dec_op = 3'b111; dec_shamt = 1'b1; end
      default: begin
        dec_valid = 1'b0;
        dec_zf    = 1'b0;
      end
    endcase
  end

  // The halt opcode is a clean stop; anything else non-R-type is illegal.
  assign halt_op  = (opcode == 6'b111111);
  assign bad_inst = !halt_op && ((opcode != 6'b000000) || !dec_valid);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_nxt;
  end

  // Next-state and strobe decode; IF strobes are Mealy on mem_ready.
  always_comb begin
    state_nxt = state_r;
    PC_Write  = 1'b0;
    IR_Write  = 1'b0;
    Write_Reg = 1'b0;
    ALU_OP    = 3'b000;
    rs_shamt  = 1'b0;
    Set_ZF    = 1'b0;
    Set_OF    = 1'b0;
    case (state_r)
      S_IDLE: if (run) state_nxt = S_IF;
      S_IF: begin
        if (mem_ready) begin
          IR_Write  = 1'b1;
          PC_Write  = 1'b1;
          state_nxt = S_ID;
        end
      end
      S_ID: begin
        if (halt_op || bad_inst) state_nxt = S_HALT;
        else                     state_nxt = S_EX;
      end
      S_EX: begin
        ALU_OP    = alu_op_r;
        rs_shamt  = shamt_r;
        Set_ZF    = zf_r;
        Set_OF    = of_r;
        state_nxt = S_WB;
      end
      S_WB: begin
        ALU_OP    = alu_op_r;
        rs_shamt  = shamt_r;
        Write_Reg = 1'b1;
        state_nxt = run ? S_IF : S_IDLE;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decode capture in ID, sticky illegal flag, and retire counter in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_r   <= 3'b000;
      shamt_r    <= 1'b0;
      zf_r       <= 1'b0;
      of_r       <= 1'b0;
      illegal_r  <= 1'b0;
      inst_cnt_r <= '0;
    end else begin
      if (state_r == S_ID) begin
        alu_op_r <= dec_op;
        shamt_r  <= dec_shamt;
        zf_r     <= dec_zf;
        of_r     <= dec_of;
        if (bad_inst) illegal_r <= 1'b1;
      end
      if (state_r == S_WB) inst_cnt_r <= inst_cnt_r + CNT_W'(1);
    end
  end

  assign state    = state_r;
  assign illegal  = illegal_r;
  assign halted   = (state_r == S_HALT);
  assign inst_cnt = inst_cnt_r;

endmodule

// File: tb/tb_r_cpu_ctrl.sv
// Directed bench for r_cpu_ctrl with CNT_W=4 so counter wrap is reachable.
// Output vector layout: {state, PC_Write, IR_Write, Write_Reg, ALU_OP,
// rs_shamt, Set_ZF, Set_OF}.
module tb_r_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, mem_ready;
  logic [5:0] opcode, func;
  logic       PC_Write, IR_Write, Write_Reg, rs_shamt, Set_ZF, Set_OF;
  logic [2:0] ALU_OP, state;
  logic       illegal, halted;
  logic [3:0] inst_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [11:0] V_IDLE  = 12'b000_0_0_0_000_0_0_0;
  localparam logic [11:0] V_IF    = 12'b001_1_1_0_000_0_0_0;
  localparam logic [11:0] V_IFW   = 12'b001_0_0_0_000_0_0_0;
  localparam logic [11:0] V_ID    = 12'b010_0_0_0_000_0_0_0;
  localparam logic [11:0] V_HALT  = 12'b101_0_0_0_000_0_0_0;
  localparam logic [11:0] ADD_EX  = 12'b011_0_0_0_100_0_1_1;
  localparam logic [11:0] ADD_WB  = 12'b100_0_0_1_100_0_0_0;
  localparam logic [11:0] SLL_EX  = 12'b011_0_0_0_111_1_1_0;
  localparam logic [11:0] SLL_WB  = 12'b100_0_0_1_111_1_0_0;
  localparam logic [11:0] AND_EX  = 12'b011_0_0_0_000_0_1_0;
  localparam logic [11:0] AND_WB  = 12'b100_0_0_1_000_0_0_0;
  localparam logic [11:0] SUB_EX  = 12'b011_0_0_0_101_0_1_1;

  always #5 clk = ~clk;

  r_cpu_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready),
    .opcode(opcode), .func(func),
    .PC_Write(PC_Write), .IR_Write(IR_Write), .Write_Reg(Write_Reg),
    .ALU_OP(ALU_OP), .rs_shamt(rs_shamt), .Set_ZF(Set_ZF), .Set_OF(Set_OF),
    .state(state), .illegal(illegal), .halted(halted), .inst_cnt(inst_cnt)
  );

  function automatic logic [11:0] ov();
    return {state, PC_Write, IR_Write, Write_Reg, ALU_OP, rs_shamt, Set_ZF, Set_OF};
  endfunction

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 6'd0; func = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b100000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ov() !== V_IDLE) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", ov(), V_IDLE);
    end
    checks++;
    if ({illegal, halted, inst_cnt} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=%b", {illegal, halted, inst_cnt}, 6'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [11:0] exp_v [4];
    exp_v = '{V_IF, V_ID, ADD_EX, ADD_WB};
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ov() !== exp_v[i]) begin
        errors++; $display("FAIL add_cycle%0d got=%b exp=%b", i, ov(), exp_v[i]);
      end
      if (i == 3) run = 1'b0;
    end
    tick();
    checks++;
    if (ov() !== V_IDLE || inst_cnt !== 4'd1) begin
      errors++; $display("FAIL add_retire got=%b cnt=%0d exp=%b cnt=1", ov(), inst_cnt, V_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_v [8];
    exp_v = '{V_IF, V_ID, SLL_EX, SLL_WB, V_IF, V_ID, AND_EX, AND_WB};
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (ov() !== exp_v[i]) begin
        errors++; $display("FAIL sll_and_cycle%0d got=%b exp=%b", i, ov(), exp_v[i]);
      end
      if (i == 3) func = 6'b100100;
      if (i == 7) run = 1'b0;
    end
    tick();
    checks++;
    if (ov() !== V_IDLE || inst_cnt !== 4'd2) begin
      errors++; $display("FAIL sll_and_cnt got=%b cnt=%0d exp=%b cnt=2", ov(), inst_cnt, V_IDLE);
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] exp_v [3];
    exp_v = '{V_ID, ADD_EX, ADD_WB};
    apply_reset();
    run = 1'b1; mem_ready = 1'b0; opcode = 6'd0; func = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ov() !== V_IFW) begin
        errors++; $display("FAIL wait_cycle%0d got=%b exp=%b", i, ov(), V_IFW);
      end
      if (i == 1) run = 1'b0;
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ov() !== V_IF) begin
      errors++; $display("FAIL wait_fetch got=%b exp=%b", ov(), V_IF);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ov() !== exp_v[i]) begin
        errors++; $display("FAIL wait_cycle_post%0d got=%b exp=%b", i, ov(), exp_v[i]);
      end
    end
    tick();
    checks++;
    if (ov() !== V_IDLE || inst_cnt !== 4'd1) begin
      errors++; $display("FAIL wait_stop got=%b cnt=%0d exp=%b cnt=1", ov(), inst_cnt, V_IDLE);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'b001000; func = 6'b100000;
    tick();
    tick();
    checks++;
    if (ov() !== V_ID || illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_id got=%b ill=%b exp=%b ill=0", ov(), illegal, V_ID);
    end
    tick();
    checks++;
    if (ov() !== V_HALT || illegal !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL illegal_halt got=%b ill=%b hlt=%b exp=%b ill=1 hlt=1", ov(), illegal, halted, V_HALT);
    end
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick();
      checks++;
      if (ov() !== V_HALT || inst_cnt !== 4'd0) begin
        errors++; $display("FAIL halt_hold%0d got=%b cnt=%0d exp=%b cnt=0", i, ov(), inst_cnt, V_HALT);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ov() !== V_IDLE || {illegal, halted} !== 2'b00) begin
      errors++; $display("FAIL halt_reset got=%b ill=%b hlt=%b exp=%b ill=0 hlt=0", ov(), illegal, halted, V_IDLE);
    end
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'b111111; func = 6'b100000;
    repeat (3) tick();
    checks++;
    if (ov() !== V_HALT || illegal !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_opcode got=%b ill=%b hlt=%b exp=%b ill=0 hlt=1", ov(), illegal, halted, V_HALT);
    end
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b000001;
    repeat (3) tick();
    checks++;
    if (ov() !== V_HALT || illegal !== 1'b1) begin
      errors++; $display("FAIL bad_func got=%b ill=%b exp=%b ill=1", ov(), illegal, V_HALT);
    end
  endtask

  task automatic test_rst_mid();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b100010;
    repeat (3) tick();
    checks++;
    if (ov() !== SUB_EX) begin
      errors++; $display("FAIL sub_ex got=%b exp=%b", ov(), SUB_EX);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ov() !== V_IDLE || inst_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid got=%b cnt=%0d exp=%b cnt=0", ov(), inst_cnt, V_IDLE);
    end
    tick();
    checks++;
    if (ov() !== V_IDLE || inst_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_hold got=%b cnt=%0d exp=%b cnt=0", ov(), inst_cnt, V_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    run = 1'b1; mem_ready = 1'b1; opcode = 6'd0; func = 6'b100000;
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (c == 61) begin
        checks++;
        if (ov() !== V_IF || inst_cnt !== 4'd15) begin
          errors++; $display("FAIL wrap_15 got=%b cnt=%0d exp=%b cnt=15", ov(), inst_cnt, V_IF);
        end
      end
      if (c == 64) begin
        checks++;
        if (ov() !== ADD_WB) begin
          errors++; $display("FAIL wrap_wb got=%b exp=%b", ov(), ADD_WB);
        end
        run = 1'b0;
      end
      if (c == 65) begin
        checks++;
        if (ov() !== V_IDLE || inst_cnt !== 4'd0) begin
          errors++; $display("FAIL wrap_0 got=%b cnt=%0d exp=%b cnt=0", ov(), inst_cnt, V_IDLE);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mem_wait();
    test_illegal();
    test_rst_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached=1 expected=0");
    $fatal(1);
  end

endmodule
